// File: rtl/dmem_loader_pkg.sv
// Shared constants and state encoding for the data-memory byte-stream preloader.
package dmem_loader_pkg;

  localparam int DEF_MEM_BYTES  = 256;
  localparam int DEF_CNT_W      = 16;
  localparam int DATA_W         = 32;
  localparam int HDR_ADDR_BYTES = 4;
  localparam int HDR_CNT_BYTES  = 2;
  localparam int WORD_BYTES     = 4;

  typedef enum logic [2:0] {
    HDR_A,
    HDR_N,
    DATA,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/dmem_loader_if.sv
// Byte-stream input and data_memory external write bus of the preloader.
interface dmem_loader_if;
  import dmem_loader_pkg::*;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] ext_data_addr;
  logic              ext_data_en;

  modport master (
    output in_valid, in_data,
    input  in_ready, ext_data, ext_data_addr, ext_data_en
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ext_data, ext_data_addr, ext_data_en
  );

endinterface

// File: rtl/dmem_loader_be_word_packer.sv
// Big-endian 32-bit byte assembler: each shifted byte enters at [7:0], so the first byte ends in [31:24].
module be_word_packer
  import dmem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] next_word,
  output logic [2:0]        count,
  output logic              full
);

  logic [DATA_W-1:0] word_q, word_d;
  logic [2:0]        count_q, count_d;

  assign next_word = {word_q[DATA_W-9:0], byte_in};
  assign count     = count_q;
  // full flags the shift that completes a word, so the caller can capture next_word in the same cycle
  assign full      = en && (count_q == 3'(WORD_BYTES - 1));

  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    if (clear) begin
      word_d  = '0;
      count_d = '0;
    end else if (en) begin
      word_d  = next_word;
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      count_q <= '0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dmem_loader.sv
// Frame parser: 4-byte start address, 2-byte word count, then big-endian words written to data_memory.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int MEM_BYTES = DEF_MEM_BYTES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_loader_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_written
);

  localparam int SUM_W = 34 + CNT_W;
  localparam logic [SUM_W-1:0] MEM_LIMIT = SUM_W'(MEM_BYTES);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  words_written_q, words_written_d;
  logic [DATA_W-1:0] ext_data_q, ext_data_d;
  logic [DATA_W-1:0] ext_addr_q, ext_addr_d;
  logic              ext_en_q, ext_en_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              transfer;
  logic              pk_en, pk_clear, pk_full;
  logic [DATA_W-1:0] pk_word;
  logic [2:0]        pk_count;
  logic [CNT_W-1:0]  hdr_n;

  // The end address is formed wide enough that a huge count can never wrap back into range
  function automatic logic hdr_reject(input logic [DATA_W-1:0] a, input logic [CNT_W-1:0] n);
    logic [SUM_W-1:0] end_addr;
    end_addr = {{(SUM_W-DATA_W){1'b0}}, a} + {{DATA_W{1'b0}}, n, 2'b00};
    return (a[1:0] != 2'b00) || (end_addr > MEM_LIMIT);
  endfunction

  be_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .en        (pk_en),
    .byte_in   (bus.in_data),
    .next_word (pk_word),
    .count     (pk_count),
    .full      (pk_full)
  );

  assign transfer = bus.in_valid && in_ready_q;
  assign hdr_n    = pk_word[CNT_W-1:0];

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    words_written_d = words_written_q;
    ext_data_d      = ext_data_q;
    ext_addr_d      = ext_addr_q;
    busy_d          = busy_q;
    err_d           = err_q;
    pk_en           = 1'b0;
    pk_clear        = 1'b0;

    unique case (state_q)
      HDR_A: begin
        if (transfer) begin
          pk_en = 1'b1;
          if (pk_count == 3'd0) begin
            busy_d          = 1'b1;
            err_d           = 1'b0;
            words_written_d = '0;
          end
          if (pk_full) begin
            addr_d   = pk_word;
            pk_clear = 1'b1;
            state_d  = HDR_N;
          end
        end
      end
      HDR_N: begin
        if (transfer) begin
          pk_en = 1'b1;
          if (pk_count == 3'(HDR_CNT_BYTES - 1)) begin
            pk_clear    = 1'b1;
            remaining_d = hdr_n;
            err_d       = hdr_reject(addr_q, hdr_n);
            state_d     = (hdr_n != '0) ? DATA : DONE;
          end
        end
      end
      DATA: begin
        if (transfer) begin
          pk_en = 1'b1;
          if (pk_full) begin
            pk_clear = 1'b1;
            if (!err_q) begin
              ext_data_d = pk_word;
              ext_addr_d = addr_q;
            end
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d      = addr_q + 32'd4;
        remaining_d = remaining_q - CNT_W'(1);
        if (!err_q) begin
          words_written_d = words_written_q + CNT_W'(1);
        end
        state_d = (remaining_q != CNT_W'(1)) ? DATA : DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = HDR_A;
      end
      default: state_d = HDR_A;
    endcase

    // Handshake and strobe outputs are registered copies of what the next state implies
    in_ready_d = (state_d == HDR_A) || (state_d == HDR_N) || (state_d == DATA);
    ext_en_d   = (state_d == WRITE) && !err_d;
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= HDR_A;
      addr_q          <= '0;
      remaining_q     <= '0;
      words_written_q <= '0;
      ext_data_q      <= '0;
      ext_addr_q      <= '0;
      ext_en_q        <= 1'b0;
      in_ready_q      <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      words_written_q <= words_written_d;
      ext_data_q      <= ext_data_d;
      ext_addr_q      <= ext_addr_d;
      ext_en_q        <= ext_en_d;
      in_ready_q      <= in_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.ext_data      = ext_data_q;
  assign bus.ext_data_addr = ext_addr_q;
  assign bus.ext_data_en   = ext_en_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign words_written     = words_written_q;

endmodule

// File: tb/tb_dmem_loader.sv
// Directed frames against a frame-level model of the loader; every observed strobe is scoreboarded.
module tb_dmem_loader;
  import dmem_loader_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } strobe_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy, done, err;
  logic [15:0] words_written;

  int      tests_run = 0;
  int      tests_failed = 0;
  strobe_t exp_q[$];
  strobe_t log_q[$];
  bit      random_gaps = 0;
  logic    prev_done = 1'b0;
  int      lat;

  always #5 clk = ~clk;

  dmem_loader_if lif();

  dmem_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (lif),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_written (words_written)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Frame-level model: a frame is rejected when misaligned or when it would run past the memory end
  task automatic model_frame(input logic [31:0] addr, input int n, input logic [7:0] data[$], output bit rejected);
    rejected = (addr % 4 != 0) || (longint'(addr) + 4 * longint'(n) > 256);
    if (!rejected) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{addr + 32'(4 * i),
                          {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]}});
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    if (random_gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        lif.in_data = 8'($urandom);
      end
    end
    @(negedge clk);
    lif.in_data  = b;
    lif.in_valid = 1'b1;
    guard = 0;
    while (lif.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_output("ready_timeout", 64'(lif.in_ready), 64'd1);
    @(posedge clk);
    #1 lif.in_valid = 1'b0;
  endtask

  task automatic send_header(input logic [31:0] addr, input logic [15:0] n, input bit probe_first);
    send_byte(addr[31:24]);
    if (probe_first) begin
      @(negedge clk);
      check_output("err_clear_on_first", 64'(err), 64'd0);
      check_output("ww_clear_on_first", 64'(words_written), 64'd0);
      check_output("busy_on_first", 64'(busy), 64'd1);
    end
    send_byte(addr[23:16]);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic run_frame(input logic [31:0] addr, input int n, input logic [7:0] data[$], output int latency);
    bit rejected;
    model_frame(addr, n, data, rejected);
    send_header(addr, 16'(n), 1'b1);
    for (int i = 0; i < 4 * n; i++) send_byte(data[i]);
    latency = 0;
    do begin
      @(negedge clk);
      latency++;
    end while (done !== 1'b1 && latency < 100);
    check_output("done_seen", 64'(done), 64'd1);
    check_output("err_at_done", 64'(err), 64'(rejected));
    check_output("ww_at_done", 64'(words_written), rejected ? 64'd0 : 64'(n));
    check_output("busy_at_done", 64'(busy), 64'd1);
    @(negedge clk);
    check_output("busy_after_done", 64'(busy), 64'd0);
    check_output("done_after_done", 64'(done), 64'd0);
    check_output("ready_after_done", 64'(lif.in_ready), 64'd1);
  endtask

  task automatic check_log(input int idx, input logic [31:0] addr, input logic [31:0] data);
    if (idx >= log_q.size()) begin
      check_output("log_missing", 64'(log_q.size()), 64'(idx + 1));
    end else begin
      check_output("log_addr", 64'(log_q[idx].addr), 64'(addr));
      check_output("log_data", 64'(log_q[idx].data), 64'(data));
    end
  endtask

  // Compare process: every strobe must match the model, and the loader may never accept during WRITE/DONE
  always @(negedge clk) begin
    strobe_t e;
    if (rst_n === 1'b1) begin
      if (lif.ext_data_en === 1'b1) begin
        log_q.push_back('{lif.ext_data_addr, lif.ext_data});
        if (exp_q.size() == 0) begin
          check_output("unexpected_strobe", 64'(lif.ext_data_en), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("strobe_addr", 64'(lif.ext_data_addr), 64'(e.addr));
          check_output("strobe_data", 64'(lif.ext_data), 64'(e.data));
        end
        check_output("ready_in_write", 64'(lif.in_ready), 64'd0);
      end
      if (done === 1'b1) begin
        check_output("ready_in_done", 64'(lif.in_ready), 64'd0);
        check_output("done_width", 64'(prev_done), 64'd0);
      end
    end
    prev_done = done;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] d1[$];
    logic [7:0] d3[$];
    logic [7:0] d4a[$];
    logic [7:0] d4b[$];
    logic [7:0] d6[$];
    logic [7:0] none[$];
    d1   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    d3   = '{8'h55, 8'h66, 8'h77, 8'h88};
    d4a  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    d4b  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    d6   = '{8'h01, 8'h02, 8'h03, 8'h04};
    none = {};

    lif.in_valid = 1'b0;
    lif.in_data  = 8'h00;
    rst_n        = 1'b0;
    #12;
    check_output("rst_en", 64'(lif.ext_data_en), 64'd0);
    check_output("rst_data", 64'(lif.ext_data), 64'd0);
    check_output("rst_addr", 64'(lif.ext_data_addr), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_err", 64'(err), 64'd0);
    check_output("rst_ww", 64'(words_written), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("ready_after_reset", 64'(lif.in_ready), 64'd1);

    // 1: two good words at 0x10; last data byte -> WRITE -> DONE gives latency 2
    log_q = {};
    run_frame(32'h10, 2, d1, lat);
    check_output("t1_latency", 64'(lat), 64'd2);
    check_output("t1_log_size", 64'(log_q.size()), 64'd2);
    check_log(0, 32'h10, 32'h11223344);
    check_log(1, 32'h14, 32'hAABBCCDD);

    // 2: empty frame; done right after the last header byte
    log_q = {};
    run_frame(32'h0, 0, none, lat);
    check_output("t2_latency", 64'(lat), 64'd1);
    check_output("t2_no_strobe", 64'(log_q.size()), 64'd0);

    // 3: misaligned frame is swallowed without strobes; next frame clears err
    run_frame(32'h2, 1, d3, lat);
    check_output("t3_no_strobe", 64'(log_q.size()), 64'd0);

    // 4: overrun rejected, exact fit to the last word accepted
    run_frame(32'hFC, 2, d4a, lat);
    check_output("t4a_no_strobe", 64'(log_q.size()), 64'd0);
    run_frame(32'hFC, 1, d4b, lat);
    check_log(0, 32'hFC, 32'hDEADBEEF);

    // 5: frame 1 again with random idle gaps
    log_q = {};
    random_gaps = 1;
    run_frame(32'h10, 2, d1, lat);
    random_gaps = 0;
    check_log(0, 32'h10, 32'h11223344);
    check_log(1, 32'h14, 32'hAABBCCDD);

    // 6: reset after two data bytes, then a clean frame
    log_q = {};
    send_header(32'h20, 16'd1, 1'b0);
    send_byte(8'hF1);
    send_byte(8'hF2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("t6_rst_data", 64'(lif.ext_data), 64'd0);
    check_output("t6_rst_addr", 64'(lif.ext_data_addr), 64'd0);
    check_output("t6_rst_busy", 64'(busy), 64'd0);
    check_output("t6_rst_ww", 64'(words_written), 64'd0);
    check_output("t6_rst_en", 64'(lif.ext_data_en), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(32'h30, 1, d6, lat);
    check_output("t6_log_size", 64'(log_q.size()), 64'd1);
    check_log(0, 32'h30, 32'h01020304);

    repeat (3) @(negedge clk);
    check_output("pending_strobes", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
